adder_pipelined_nbit: RTL and testbench
=======================================

# adder_pipelined_nbit

Parametrised, pipelined two's-complement adder/subtractor. Splits a BIT_WIDTH operand pair into NUM_STAGES equal slices, with one slice and a registered carry per stage, so wide adds close timing at high clock rates. It sits in the datapath wherever a wide add/sub must run at full throughput: one result per cycle, a valid/ready handshake on both sides, and carry and signed overflow flags.

## Interface
- BIT_WIDTH, 16, operand/result width; must be a multiple of NUM_STAGES
- NUM_STAGES, 4, pipeline depth and slice count; slice width W = BIT_WIDTH/NUM_STAGES, W ≥ 1
- clk  input  1  rising-edge clock; the block's only clock
- n_rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  input  1  a, b, carry_in, sub_mode are valid this cycle
- in_ready  output  1  block accepts an operation this cycle
- a  input  BIT_WIDTH  operand A
- b  input  BIT_WIDTH  operand B
- carry_in  input  1  carry into bit 0 (add mode only)
- sub_mode  input  1  0: a+b+carry_in; 1: a−b (carry_in ignored)
- out_valid  output  1  result outputs valid
- out_ready  input  1  downstream accepts the result
- sum  output  BIT_WIDTH  result modulo 2^BIT_WIDTH
- carry_out  output  1  carry out of the MSB; in sub mode 1 means no borrow (a ≥ b unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- Operation accepted when in_valid && in_ready; advance = !out_valid || out_ready; in_ready = advance (global stall, no bubbles collapsed).
- Stage 0 captures a, b' = sub_mode ? ~b : b, and c0 = sub_mode ? 1 : carry_in; adds slice 0 (bits W−1:0) + c0; registers slice sum and slice carry.
- Stage k (1..NUM_STAGES−1) adds slice k of skew-delayed a/b' with registered carry from stage k−1.
- Operand slices not yet consumed travel in skew registers; finished sum slices travel in deskew registers, so all slices of one operation exit together.
- Final stage also registers carry into MSB (from its slice) to form overflow.
- Per-stage valid bit shifts with advance; out_valid = valid of last stage.
- When advance = 0, every pipeline register (data, carries, valids) holds.
- Reset (n_rst = 0 at a clock edge): all valid bits 0, sum = 0, carry_out = 0, overflow = 0; in-flight operations discarded. Because valid is cleared, in_ready = 1 on the first cycle after reset.
- Reset has priority over an accept or advance in the same cycle.
- NUM_STAGES = 1: a single registered full-width adder, latency 1.

## Timing
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+NUM_STAGES−1 (NUM_STAGES register stages), provided no stall occurs.
- Throughput: one operation per cycle while out_ready = 1.
- A stall of S cycles adds exactly S cycles of latency to every in-flight operation; order is preserved and no operation is lost or duplicated.
- sum, carry_out and overflow are stable while out_valid && !out_ready.
- Outputs are all registered; no combinational path from a/b to sum. in_ready depends combinationally on out_ready only.

## Structure
- Shared package adder_pkg: slice-width function and a typedef for the stage valid/carry vector. Add a localparam check (BIT_WIDTH % NUM_STAGES == 0), which errors at elaboration on failure.
- One sub-module, adder_stage: a combinational W-bit slice add with carry-in, carry-out and carry-into-MSB. It is instantiated NUM_STAGES times in a generate loop; the registers live in the top.
- Bench includes immediate assertions: X on a/b when in_valid = 1; sum vs a reference model on every out_valid.

## Test plan
- BIT_WIDTH=16, NUM_STAGES=4, add 0xFFFF+0x0001, carry_in=0 -> sum 0x0000, carry_out 1, overflow 0, out_valid exactly 4 edges after accept.
- Add 0x7FFF+0x0001 -> sum 0x8000, carry_out 0, overflow 1; add 0x0000+0x0000, carry_in=1 -> sum 0x0001.
- Sub 0x0005−0x0007 -> sum 0xFFFE, carry_out 0, overflow 0; sub 0x8000−0x0001 -> sum 0x7FFF, carry_out 1, overflow 1.
- Stream 8 back-to-back random ops, out_ready=1 -> 8 correct results on 8 consecutive cycles, in order.
- With the pipe full, drop out_ready for 3 cycles -> in_ready 0, outputs held, no loss; resume -> remaining results in order.
- Assert n_rst=0 for one cycle mid-stream -> next cycle out_valid 0, sum 0, in_ready 1; first op after reset correct at latency 4.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: slice sizing and the per-stage
// valid/carry control word.
package adder_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   function automatic int unsigned slice_width(input int unsigned bit_width,
                                               input int unsigned num_stages);
      return bit_width / num_stages;
   endfunction

endpackage

// File: rtl/adder_stage.sv
// Combinational slice adder: W-bit sum with carry-in, carry-out and the carry that
// entered the slice MSB (needed for signed overflow on the top slice).
module adder_stage #(
   parameter int unsigned Width = 4
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             carry_i,
   output logic [Width-1:0] sum_o,
   output logic             carry_o,
   output logic             carry_msb_o
);

   logic [Width:0] full;

   always_comb begin
      full        = {1'b0, a_i} + {1'b0, b_i} + {{Width{1'b0}}, carry_i};
      sum_o       = full[Width-1:0];
      carry_o     = full[Width];
      // sum bit = a ^ b ^ cin, so the carry into the MSB falls out of the sum bit
      carry_msb_o = full[Width-1] ^ a_i[Width-1] ^ b_i[Width-1];
   end

endmodule

// File: rtl/adder_pipelined_nbit.sv
// Pipelined add/sub: one W-bit slice and one registered carry per stage, operand skew
// and result deskew so all slices of an operation leave together.
module adder_pipelined_nbit
   import adder_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 16,
   parameter int unsigned NUM_STAGES = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   input  logic                 sub_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow
);

   localparam int unsigned W       = slice_width(BIT_WIDTH, NUM_STAGES);
   localparam bit          WidthOk = (NUM_STAGES >= 1) && (W >= 1)
                                     && ((BIT_WIDTH % NUM_STAGES) == 0);

   if (!WidthOk) begin : g_bad_width
      $error("BIT_WIDTH must be a non-zero multiple of NUM_STAGES");
   end

   logic                 advance;
   logic [BIT_WIDTH-1:0] b_eff;
   logic                 c0;

   logic [BIT_WIDTH-1:0] opa_q [NUM_STAGES];
   logic [BIT_WIDTH-1:0] opa_d [NUM_STAGES];
   logic [BIT_WIDTH-1:0] opb_q [NUM_STAGES];
   logic [BIT_WIDTH-1:0] opb_d [NUM_STAGES];
   logic [BIT_WIDTH-1:0] sum_q [NUM_STAGES];
   logic [BIT_WIDTH-1:0] sum_d [NUM_STAGES];
   stage_ctl_t           ctl_q [NUM_STAGES];
   stage_ctl_t           ctl_d [NUM_STAGES];
   logic                 cmsb_q;

   logic [NUM_STAGES-1:0][W-1:0] stg_a;
   logic [NUM_STAGES-1:0][W-1:0] stg_b;
   logic [NUM_STAGES-1:0][W-1:0] stg_sum;
   logic [NUM_STAGES-1:0]        stg_c;
   logic [NUM_STAGES-1:0]        stg_cout;
   logic                         stg_cmsb [NUM_STAGES];

   // Global stall: nothing moves unless the last stage is empty or being drained.
   assign advance   = !ctl_q[NUM_STAGES-1].valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = ctl_q[NUM_STAGES-1].valid;
   assign sum       = sum_q[NUM_STAGES-1];
   assign carry_out = ctl_q[NUM_STAGES-1].carry;
   assign overflow  = ctl_q[NUM_STAGES-1].carry ^ cmsb_q;

   always_comb begin : stage_inputs
      b_eff    = sub_mode ? ~b : b;
      c0       = sub_mode | carry_in;
      stg_a    = '0;
      stg_b    = '0;
      stg_c    = '0;
      stg_a[0] = a[W-1:0];
      stg_b[0] = b_eff[W-1:0];
      stg_c[0] = c0;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
         stg_a[k] = opa_q[k-1][k*W +: W];
         stg_b[k] = opb_q[k-1][k*W +: W];
         stg_c[k] = ctl_q[k-1].carry;
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
      adder_stage #(
         .Width (W)
      ) u_stage (
         .a_i         (stg_a[k]),
         .b_i         (stg_b[k]),
         .carry_i     (stg_c[k]),
         .sum_o       (stg_sum[k]),
         .carry_o     (stg_cout[k]),
         .carry_msb_o (stg_cmsb[k])
      );
   end

   always_comb begin : next_state
      opa_d[0]          = a;
      opb_d[0]          = b_eff;
      sum_d[0]          = '0;
      sum_d[0][W-1:0]   = stg_sum[0];
      ctl_d[0].valid    = in_valid;
      ctl_d[0].carry    = stg_cout[0];
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
         opa_d[k]            = opa_q[k-1];
         opb_d[k]            = opb_q[k-1];
         sum_d[k]            = sum_q[k-1];
         sum_d[k][k*W +: W]  = stg_sum[k];
         ctl_d[k].valid      = ctl_q[k-1].valid;
         ctl_d[k].carry      = stg_cout[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            sum_q[k] <= '0;
            ctl_q[k] <= '0;
         end
         cmsb_q <= 1'b0;
      end else if (advance) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            sum_q[k] <= sum_d[k];
            ctl_q[k] <= ctl_d[k];
         end
         cmsb_q <= stg_cmsb[NUM_STAGES-1];
      end
   end

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Bench for adder_pipelined_nbit: directed literal vectors plus an arithmetic reference
// queue checked every cycle against the DUT outputs and handshake.
module tb_adder_pipelined_nbit;

   localparam int unsigned BW = 16;
   localparam int unsigned NS = 4;

   logic          clk;
   logic          n_rst;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] a;
   logic [BW-1:0] b;
   logic          carry_in;
   logic          sub_mode;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] sum;
   logic          carry_out;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [BW-1:0] s;
      logic          co;
      logic          ov;
      int            due;
   } exp_t;

   exp_t q[$];

   adder_pipelined_nbit #(
      .BIT_WIDTH  (BW),
      .NUM_STAGES (NS)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub_mode  (sub_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input logic [BW-1:0] av, input logic [BW-1:0] bv,
                                  input logic ci, input logic sb);
      exp_t   r;
      longint ua, ub, sa, sbs, ur, sr;
      ua  = longint'(av);
      ub  = longint'(bv);
      sa  = longint'($signed(av));
      sbs = longint'($signed(bv));
      if (sb) begin
         ur   = ua - ub;
         sr   = sa - sbs;
         r.co = (ua >= ub);
      end else begin
         ur   = ua + ub + longint'(ci);
         sr   = sa + sbs + longint'(ci);
         r.co = (ur > 65535);
      end
      r.s   = ur[15:0];
      r.ov  = (sr > 32767) || (sr < -32768);
      r.due = 0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (n_rst === 1'b1 && in_valid === 1'b1)
         assert (!$isunknown({a, b})) else $error("X on operands while in_valid");
   end

   always @(negedge clk) begin : compare
      exp_t e;
      bit   exp_valid;
      if (n_rst !== 1'b1) begin
         q.delete();
      end else begin
         exp_valid = (q.size() > 0) && (q[0].due == cyc);
         chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
         chk("in_ready", {31'b0, in_ready}, {31'b0, (!exp_valid || out_ready)});
         if (exp_valid && out_valid === 1'b1) begin
            checks++;
            assert ({sum, carry_out, overflow} === {q[0].s, q[0].co, q[0].ov}) else begin
               errors++;
               $display("FAIL result: got sum %h co %b ov %b expected sum %h co %b ov %b",
                        sum, carry_out, overflow, q[0].s, q[0].co, q[0].ov);
            end
         end
         if (exp_valid && !out_ready) begin
            foreach (q[i]) q[i].due++;
         end else if (exp_valid) begin
            void'(q.pop_front());
         end
         if (in_valid === 1'b1 && (!exp_valid || out_ready)) begin
            e     = model(a, b, carry_in, sub_mode);
            e.due = cyc + NS;
            q.push_back(e);
         end
      end
   end

   // Called at posedge+1 with an empty pipe; checks latency and literal results.
   task automatic single(input logic [BW-1:0] av, input logic [BW-1:0] bv, input logic ci,
                         input logic sb, input logic [BW-1:0] es, input logic eco,
                         input logic eov, input string nm);
      int edges;
      a        = av;
      b        = bv;
      carry_in = ci;
      sub_mode = sb;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      edges = 1;
      while (edges < 12) begin
         @(negedge clk);
         if (out_valid === 1'b1) break;
         @(posedge clk);
         #1 edges++;
      end
      chk({nm, "_latency"}, edges, NS);
      chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
      chk({nm, "_carry"}, {31'b0, carry_out}, {31'b0, eco});
      chk({nm, "_ovf"}, {31'b0, overflow}, {31'b0, eov});
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [BW-1:0] av, input logic [BW-1:0] bv, input logic ci,
                       input logic sb);
      bit acc;
      int tries;
      tries    = 0;
      a        = av;
      b        = bv;
      carry_in = ci;
      sub_mode = sb;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = (in_ready === 1'b1);
         @(posedge clk);
         #1 tries++;
      end while (!acc && tries < 50);
      if (!acc) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t m;
      n_rst     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      carry_in  = 1'b0;
      sub_mode  = 1'b0;

      m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      chk("model_pin_add_ovf", {15'b0, m.s, m.co, m.ov}, {15'b0, 16'h8000, 1'b0, 1'b1});
      m = model(16'h8000, 16'h0001, 1'b0, 1'b1);
      chk("model_pin_sub_ovf", {15'b0, m.s, m.co, m.ov}, {15'b0, 16'h7FFF, 1'b1, 1'b1});

      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_sum", {16'b0, sum}, 0);
      chk("rst_carry", {31'b0, carry_out}, 0);
      chk("rst_ovf", {31'b0, overflow}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1 n_rst = 1'b1;

      single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
      single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      single(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "add_cin");
      single(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      single(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_cin_ignored");

      // Back-to-back stream at full throughput
      for (int i = 0; i < 8; i++) send_rand();
      repeat (6) @(posedge clk);
      #1;

      // Fill the pipe, then stall the output for three cycles
      for (int i = 0; i < 4; i++) send_rand();
      fork
         begin
            for (int i = 0; i < 4; i++) send_rand();
         end
         begin
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", {31'b0, in_ready}, 0);
               chk("stall_out_valid", {31'b0, out_valid}, 1);
               @(posedge clk);
            end
            #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // One-cycle reset in the middle of a stream
      fork
         begin
            for (int i = 0; i < 10; i++) send_rand();
         end
         begin
            repeat (5) @(posedge clk);
            #1 n_rst = 1'b0;
            @(posedge clk);
            #1 n_rst = 1'b1;
            @(negedge clk);
            chk("midrst_out_valid", {31'b0, out_valid}, 0);
            chk("midrst_sum", {16'b0, sum}, 0);
            chk("midrst_carry", {31'b0, carry_out}, 0);
            chk("midrst_ovf", {31'b0, overflow}, 0);
            chk("midrst_in_ready", {31'b0, in_ready}, 1);
         end
      join
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
